// File: rtl/l2_pkg.sv
// Shared types and constants for the unified direct-mapped write-back L2 cache.
package l2_pkg;

  localparam int LINE_W  = 128;
  localparam int LADDR_W = 28;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP  = 3'd1,
    WB   = 3'd2,
    FILL = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  // On a conflict the side that was not served last wins, so neither side starves.
  function automatic src_t pick_src(input logic req_i, input logic req_d, input src_t last);
    if (req_i && req_d) begin
      return (last == SRC_I) ? SRC_D : SRC_I;
    end else if (req_d) begin
      return SRC_D;
    end else begin
      return SRC_I;
    end
  endfunction

endpackage

// File: rtl/l2_cache_if.sv
// Bus bundle for the L2: the two L1 miss ports on the core side and the single memory line port.
interface l2_cache_if;
  import l2_pkg::*;

  logic               l1i_read;
  logic               l1i_write;
  logic [LADDR_W-1:0] l1i_addr;
  logic [LINE_W-1:0]  l1i_wdata;
  logic [LINE_W-1:0]  l1i_rdata;
  logic               l1i_ready;

  logic               l1d_read;
  logic               l1d_write;
  logic [LADDR_W-1:0] l1d_addr;
  logic [LINE_W-1:0]  l1d_wdata;
  logic [LINE_W-1:0]  l1d_rdata;
  logic               l1d_ready;

  logic               mem_read;
  logic               mem_write;
  logic [LADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wdata;
  logic [LINE_W-1:0]  mem_rdata;
  logic               mem_ready;

  // Core plus main memory: drives requests and memory responses.
  modport master (
    output l1i_read, l1i_write, l1i_addr, l1i_wdata,
    input  l1i_rdata, l1i_ready,
    output l1d_read, l1d_write, l1d_addr, l1d_wdata,
    input  l1d_rdata, l1d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

  // The cache itself.
  modport slave (
    input  l1i_read, l1i_write, l1i_addr, l1i_wdata,
    output l1i_rdata, l1i_ready,
    input  l1d_read, l1d_write, l1d_addr, l1d_wdata,
    output l1d_rdata, l1d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

endinterface

// File: rtl/l2_tag_data_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one synchronous write port.
module l2_tag_data_array
  import l2_pkg::*;
#(
  parameter  int LINES   = 64,
  localparam int INDEX_W = $clog2(LINES),
  localparam int TAG_W   = LADDR_W - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data,
  input  logic               wr_dirty
);

  logic [LINES-1:0]  valid_r;
  logic [LINES-1:0]  dirty_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [LINE_W-1:0] data_r [LINES];

  // Status bits are cleared on reset; every write installs a valid line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (we) begin
      valid_r[wr_index] <= 1'b1;
      dirty_r[wr_index] <= wr_dirty;
    end
  end

  // Tag and data are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_index];
  assign rd_dirty = dirty_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_data  = data_r[rd_index];

endmodule

// File: rtl/l2_cache.sv
// Unified direct-mapped write-back L2: round-robin I/D arbiter and miss FSM in front of one memory port.
module l2_cache
  import l2_pkg::*;
#(
  parameter int LINES = 64
) (
  input logic       clk,
  input logic       rst,
  l2_cache_if.slave bus
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = LADDR_W - INDEX_W;

  state_t             state_r;
  src_t               src_r;
  src_t               last_r;
  logic               write_r;
  logic [LADDR_W-1:0] addr_r;
  logic [LINE_W-1:0]  wdata_r;
  logic [LINE_W-1:0]  i_rdata_r;
  logic [LINE_W-1:0]  d_rdata_r;
  logic               i_ready_r;
  logic               d_ready_r;
  logic               mem_read_r;
  logic               mem_write_r;
  logic [LADDR_W-1:0] mem_addr_r;
  logic [LINE_W-1:0]  mem_wdata_r;

  logic               req_i_s;
  logic               req_d_s;
  src_t               pick_s;
  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               rd_valid_s;
  logic               rd_dirty_s;
  logic [TAG_W-1:0]   rd_tag_s;
  logic [LINE_W-1:0]  rd_data_s;
  logic               hit_s;
  logic               victim_dirty_s;
  logic               we_s;
  logic [LINE_W-1:0]  wr_data_s;
  logic               wr_dirty_s;

  assign req_i_s        = bus.l1i_read | bus.l1i_write;
  assign req_d_s        = bus.l1d_read | bus.l1d_write;
  assign pick_s         = pick_src(req_i_s, req_d_s, last_r);
  assign idx_s          = addr_r[INDEX_W-1:0];
  assign tag_s          = addr_r[LADDR_W-1:INDEX_W];
  assign hit_s          = rd_valid_s && (rd_tag_s == tag_s);
  assign victim_dirty_s = rd_valid_s && rd_dirty_s;

  l2_tag_data_array #(.LINES(LINES)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx_s),
    .rd_valid (rd_valid_s),
    .rd_dirty (rd_dirty_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .we       (we_s),
    .wr_index (idx_s),
    .wr_tag   (tag_s),
    .wr_data  (wr_data_s),
    .wr_dirty (wr_dirty_s)
  );

  // Array write: write hits and write misses install wdata dirty; a fill installs memory data clean.
  always_comb begin
    we_s       = 1'b0;
    wr_data_s  = wdata_r;
    wr_dirty_s = 1'b1;
    case (state_r)
      CMP:  we_s = write_r && (hit_s || !victim_dirty_s);
      WB:   we_s = write_r && bus.mem_ready;
      FILL: begin
        if (bus.mem_ready) begin
          we_s       = 1'b1;
          wr_data_s  = bus.mem_rdata;
          wr_dirty_s = 1'b0;
        end else begin
          we_s = 1'b0;
        end
      end
      default: we_s = 1'b0;
    endcase
  end

  // Arbiter and miss FSM; every bus output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      src_r       <= SRC_I;
      last_r      <= SRC_I;
      write_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      i_rdata_r   <= '0;
      d_rdata_r   <= '0;
      i_ready_r   <= 1'b0;
      d_ready_r   <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_i_s || req_d_s) begin
            src_r   <= pick_s;
            last_r  <= pick_s;
            state_r <= CMP;
            if (pick_s == SRC_D) begin
              addr_r  <= bus.l1d_addr;
              wdata_r <= bus.l1d_wdata;
              write_r <= bus.l1d_write && !bus.l1d_read;
            end else begin
              addr_r  <= bus.l1i_addr;
              wdata_r <= bus.l1i_wdata;
              write_r <= bus.l1i_write && !bus.l1i_read;
            end
          end
        end
        CMP: begin
          if (hit_s || (write_r && !victim_dirty_s)) begin
            if (!write_r && src_r == SRC_D) d_rdata_r <= rd_data_s;
            if (!write_r && src_r == SRC_I) i_rdata_r <= rd_data_s;
            d_ready_r <= (src_r == SRC_D);
            i_ready_r <= (src_r == SRC_I);
            state_r   <= RESP;
          end else if (victim_dirty_s) begin
            mem_write_r <= 1'b1;
            mem_addr_r  <= {rd_tag_s, idx_s};
            mem_wdata_r <= rd_data_s;
            state_r     <= WB;
          end else begin
            mem_read_r <= 1'b1;
            mem_addr_r <= addr_r;
            state_r    <= FILL;
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            mem_write_r <= 1'b0;
            if (write_r) begin
              d_ready_r <= (src_r == SRC_D);
              i_ready_r <= (src_r == SRC_I);
              state_r   <= RESP;
            end else begin
              mem_read_r <= 1'b1;
              mem_addr_r <= addr_r;
              state_r    <= FILL;
            end
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            mem_read_r <= 1'b0;
            if (src_r == SRC_D) d_rdata_r <= bus.mem_rdata;
            else                i_rdata_r <= bus.mem_rdata;
            d_ready_r <= (src_r == SRC_D);
            i_ready_r <= (src_r == SRC_I);
            state_r   <= RESP;
          end
        end
        RESP:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.l1i_rdata = i_rdata_r;
  assign bus.l1i_ready = i_ready_r;
  assign bus.l1d_rdata = d_rdata_r;
  assign bus.l1d_ready = d_ready_r;
  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: per-port read-data scoreboards, a memory model with an expected-traffic queue.
module tb_l2_cache;
  import l2_pkg::*;

  localparam int MEM_LAT = 4;

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [127:0] data;
  } mem_txn_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   mem_rd_cycles;
  int   mem_wr_cycles;
  bit   both_hi;

  logic [127:0] exp_i_q [$];
  logic [127:0] exp_d_q [$];
  mem_txn_t     exp_mem_q [$];
  logic [127:0] mem_store [logic [27:0]];
  logic [127:0] shadow [logic [27:0]];

  l2_cache_if bus ();

  l2_cache #(.LINES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [27:0] a);
    return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_mem(input bit wr, input logic [27:0] a, input logic [127:0] d);
    mem_txn_t t;
    t.wr = wr;
    t.addr = a;
    t.data = d;
    exp_mem_q.push_back(t);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_i_rdata"}, bus.l1i_rdata, 128'h0);
    chk({tag, "_d_rdata"}, bus.l1d_rdata, 128'h0);
    chk({tag, "_ctl"}, {bus.l1i_ready, bus.l1d_ready, bus.mem_read, bus.mem_write, bus.mem_addr}, 128'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 128'h0);
  endtask

  // Issue one request on a port, wait (bounded) for ready, check latency and read data, then drop.
  task automatic port_req(input bit is_d, input bit wr, input logic [27:0] a, input logic [127:0] wd,
                          input int exp_lat, input string tag);
    int lat;
    bit got;
    logic [127:0] exp_data;
    logic [127:0] obs_data;
    if (!wr) begin
      exp_data = shadow.exists(a) ? shadow[a] : pat(a);
      if (is_d) exp_d_q.push_back(exp_data);
      else      exp_i_q.push_back(exp_data);
    end else begin
      shadow[a] = wd;
    end
    if (is_d) begin
      bus.l1d_read = !wr; bus.l1d_write = wr; bus.l1d_addr = a; bus.l1d_wdata = wd;
    end else begin
      bus.l1i_read = !wr; bus.l1i_write = wr; bus.l1i_addr = a; bus.l1i_wdata = wd;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      got = is_d ? bus.l1d_ready : bus.l1i_ready;
    end
    chk({tag, "_ready"}, 128'(got), 128'h1);
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    if (!wr) begin
      obs_data = is_d ? bus.l1d_rdata : bus.l1i_rdata;
      exp_data = is_d ? exp_d_q.pop_front() : exp_i_q.pop_front();
      if (got) chk({tag, "_rdata"}, obs_data, exp_data);
    end
    @(posedge clk);
    #1;
    if (is_d) begin
      bus.l1d_read = 1'b0; bus.l1d_write = 1'b0;
    end else begin
      bus.l1i_read = 1'b0; bus.l1i_write = 1'b0;
    end
  endtask

  // Memory model: ready in the (MEM_LAT+1)th cycle of a request; each new request is scoreboarded.
  initial begin
    int cnt;
    mem_txn_t t;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 128'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_read) mem_rd_cycles++;
      if (bus.mem_write) mem_wr_cycles++;
      if (bus.mem_read && bus.mem_write) both_hi = 1'b1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end
      if (!rst && (bus.mem_read || bus.mem_write)) begin
        cnt++;
        if (cnt == 1) begin
          checks++;
          assert (exp_mem_q.size() > 0) else begin
            failures++;
            $error("FAIL mem_unexpected observed wr=%0b addr=%h expected=no traffic", bus.mem_write, bus.mem_addr);
          end
          if (exp_mem_q.size() > 0) begin
            t = exp_mem_q.pop_front();
            chk("mem_op", 128'(bus.mem_write), 128'(t.wr));
            chk("mem_addr", 128'(bus.mem_addr), 128'(t.addr));
            if (t.wr) chk("mem_wdata", bus.mem_wdata, t.data);
          end
        end
        if (cnt == MEM_LAT + 1) begin
          if (bus.mem_write) mem_store[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr] : pat(bus.mem_addr);
          bus.mem_ready = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    int rd0;
    int wr0;
    checks = 0;
    failures = 0;
    mem_rd_cycles = 0;
    mem_wr_cycles = 0;
    both_hi = 1'b0;
    rst = 1'b1;
    bus.l1i_read = 1'b0; bus.l1i_write = 1'b0; bus.l1i_addr = 28'h0; bus.l1i_wdata = 128'h0;
    bus.l1d_read = 1'b0; bus.l1d_write = 1'b0; bus.l1d_addr = 28'h0; bus.l1d_wdata = 128'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Conflict right after reset: D first, then I; both cold misses.
    exp_mem(1'b0, 28'h0003002, 128'h0);
    exp_mem(1'b0, 28'h0002001, 128'h0);
    @(negedge clk);
    fork
      port_req(1'b1, 1'b0, 28'h0003002, 128'h0, 7, "c1_d");
      port_req(1'b0, 1'b0, 28'h0002001, 128'h0, 15, "c1_i");
    join
    // Second conflict on hits: I was served last, so D wins again.
    @(negedge clk);
    fork
      port_req(1'b1, 1'b0, 28'h0003002, 128'h0, 2, "c2_d");
      port_req(1'b0, 1'b0, 28'h0002001, 128'h0, 5, "c2_i");
    join
    @(negedge clk);
    port_req(1'b1, 1'b0, 28'h0003002, 128'h0, 2, "solo_d");
    // D was served last, so now I wins the conflict.
    @(negedge clk);
    fork
      port_req(1'b1, 1'b0, 28'h0003002, 128'h0, 5, "c3_d");
      port_req(1'b0, 1'b0, 28'h0002001, 128'h0, 2, "c3_i");
    join

    // Cold read then repeat hit.
    rd0 = mem_rd_cycles;
    exp_mem(1'b0, 28'h0001000, 128'h0);
    @(negedge clk);
    port_req(1'b1, 1'b0, 28'h0001000, 128'h0, 7, "cold_rd");
    chk("cold_rd_memcycles", 128'(mem_rd_cycles - rd0), 128'd5);
    rd0 = mem_rd_cycles;
    @(negedge clk);
    port_req(1'b1, 1'b0, 28'h0001000, 128'h0, 2, "hit_rd");
    chk("hit_rd_memcycles", 128'(mem_rd_cycles - rd0), 128'd0);

    // Write hit, then conflicting read forces write-back of the dirty line.
    @(negedge clk);
    port_req(1'b1, 1'b1, 28'h0001000, {16{8'hA5}}, 2, "wr_hit");
    wr0 = mem_wr_cycles;
    exp_mem(1'b1, 28'h0001000, {16{8'hA5}});
    exp_mem(1'b0, 28'h0001040, 128'h0);
    @(negedge clk);
    port_req(1'b1, 1'b0, 28'h0001040, 128'h0, 12, "dirty_miss");
    chk("dirty_miss_wrcycles", 128'(mem_wr_cycles - wr0), 128'd5);

    // Write miss to a clean index: no fetch; a later eviction writes it back.
    rd0 = mem_rd_cycles;
    @(negedge clk);
    port_req(1'b1, 1'b1, 28'h0004005, {16{8'h5A}}, 2, "wr_miss");
    chk("wr_miss_memcycles", 128'(mem_rd_cycles - rd0), 128'd0);
    exp_mem(1'b1, 28'h0004005, {16{8'h5A}});
    exp_mem(1'b0, 28'h0004045, 128'h0);
    @(negedge clk);
    port_req(1'b1, 1'b0, 28'h0004045, 128'h0, 12, "evict_wr_miss");

    // I/D coherence on one line.
    @(negedge clk);
    port_req(1'b1, 1'b1, 28'h0002001, {16{8'hC3}}, 2, "coh_d_wr");
    @(negedge clk);
    port_req(1'b0, 1'b0, 28'h0002001, 128'h0, 2, "coh_i_rd");

    // Reset in the middle of a fill.
    @(negedge clk);
    bus.l1d_read = 1'b1; bus.l1d_addr = 28'h0007010;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("fill_mem_read", 128'(bus.mem_read), 128'h1);
    chk("fill_mem_addr", 128'(bus.mem_addr), 128'h0007010);
    rst = 1'b1;
    bus.l1d_read = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs_zero("mid_rst");
    rst = 1'b0;
    exp_mem(1'b0, 28'h0007010, 128'h0);
    @(negedge clk);
    port_req(1'b1, 1'b0, 28'h0007010, 128'h0, 7, "post_rst_rd");

    repeat (3) @(posedge clk);
    #1;
    chk("mem_rd_wr_overlap", 128'(both_hi), 128'h0);
    chk("mem_q_drained", 128'(exp_mem_q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
